// File: rtl/pll_reset_sequencer.sv
// Sequences the fabric PLL reset/lock handshake and releases the downstream domain
// resets one by one, restarting on lock loss or a software relock request.
module pll_reset_sequencer #(
   parameter int NUM_DOMAINS    = 3,
   parameter int RESET_CYCLES   = 16,
   parameter int LOCK_TIMEOUT   = 50000,
   parameter int STABLE_CYCLES  = 1024,
   parameter int STAGGER_CYCLES = 8,
   parameter int MAX_RETRIES    = 3,
   parameter int CNT_W          = 32
) (
   input  logic                   refclk,
   input  logic                   rst,
   input  logic                   pll_locked,
   input  logic                   relock_req,
   output logic                   pll_rst,
   output logic [NUM_DOMAINS-1:0] domain_rst,
   output logic                   ready,
   output logic                   fail,
   output logic [1:0]             retry_cnt,
   output logic [7:0]             lost_cnt,
   output logic [2:0]             state
);

   typedef enum logic [2:0] {
      S_RESET_PLL = 3'd0,
      S_WAIT_LOCK = 3'd1,
      S_STABLE    = 3'd2,
      S_RELEASE   = 3'd3,
      S_RUN       = 3'd4,
      S_FAIL      = 3'd5
   } state_t;

   localparam logic [NUM_DOMAINS-1:0] ALL_RST  = {NUM_DOMAINS{1'b1}};
   // Only the top bit set: the pattern just before the last domain is released.
   localparam logic [NUM_DOMAINS-1:0] LAST_RST = ALL_RST ^ (ALL_RST >> 1);
   localparam logic [CNT_W-1:0] RESET_LAST   = CNT_W'(RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
   localparam logic [1:0]       RETRY_LIMIT  = 2'(MAX_RETRIES);

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   state_t           st;
   logic [CNT_W-1:0] timer;
   logic             locked_p0;
   logic             locked_s;
   logic             lock_lost;

   assign state     = st;
   assign lock_lost = ((st == S_RELEASE) || (st == S_RUN)) && !locked_s;

   always_ff @(posedge refclk) begin
      if (rst) begin
         st         <= S_RESET_PLL;
         timer      <= '0;
         pll_rst    <= 1'b1;
         domain_rst <= ALL_RST;
         ready      <= 1'b0;
         fail       <= 1'b0;
         retry_cnt  <= '0;
         lost_cnt   <= '0;
         locked_p0  <= 1'b0;
         locked_s   <= 1'b0;
      end else begin
         locked_p0 <= pll_locked;
         locked_s  <= locked_p0;
         // Relock and lock loss share the restart path; lock loss also bumps the counter.
         if ((relock_req && (st != S_RESET_PLL)) || lock_lost) begin
            st         <= S_RESET_PLL;
            timer      <= '0;
            pll_rst    <= 1'b1;
            domain_rst <= ALL_RST;
            ready      <= 1'b0;
            fail       <= 1'b0;
            retry_cnt  <= '0;
            if (lock_lost) lost_cnt <= sat_inc8(lost_cnt);
         end else begin
            case (st)
               S_RESET_PLL: begin
                  if (timer == RESET_LAST) begin
                     st      <= S_WAIT_LOCK;
                     timer   <= '0;
                     pll_rst <= 1'b0;
                  end else begin
                     timer <= timer + CNT_W'(1);
                  end
               end
               S_WAIT_LOCK: begin
                  if (locked_s) begin
                     st    <= S_STABLE;
                     timer <= '0;
                  end else if (timer == TIMEOUT_LAST) begin
                     timer     <= '0;
                     retry_cnt <= retry_cnt + 2'd1;
                     if ((retry_cnt + 2'd1) == RETRY_LIMIT) begin
                        st   <= S_FAIL;
                        fail <= 1'b1;
                     end else begin
                        st      <= S_RESET_PLL;
                        pll_rst <= 1'b1;
                     end
                  end else begin
                     timer <= timer + CNT_W'(1);
                  end
               end
               S_STABLE: begin
                  if (!locked_s) begin
                     st    <= S_WAIT_LOCK;
                     timer <= '0;
                  end else if (timer == STABLE_LAST) begin
                     timer      <= '0;
                     domain_rst <= ALL_RST << 1;
                     if (NUM_DOMAINS == 1) begin
                        st        <= S_RUN;
                        ready     <= 1'b1;
                        retry_cnt <= '0;
                     end else begin
                        st <= S_RELEASE;
                     end
                  end else begin
                     timer <= timer + CNT_W'(1);
                  end
               end
               S_RELEASE: begin
                  // Shifting left releases the next-higher domain on each stagger step.
                  if (timer == STAGGER_LAST) begin
                     timer      <= '0;
                     domain_rst <= domain_rst << 1;
                     if (domain_rst == LAST_RST) begin
                        st        <= S_RUN;
                        ready     <= 1'b1;
                        retry_cnt <= '0;
                     end
                  end else begin
                     timer <= timer + CNT_W'(1);
                  end
               end
               S_RUN, S_FAIL: begin
               end
               default: begin
                  st         <= S_RESET_PLL;
                  timer      <= '0;
                  pll_rst    <= 1'b1;
                  domain_rst <= ALL_RST;
                  ready      <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer: per-cycle vector table plus a lock-loss saturation loop.
module tb_pll_reset_sequencer;

   logic       refclk = 1'b0;
   logic       rst;
   logic       pll_locked;
   logic       relock_req;
   logic       pll_rst;
   logic [2:0] domain_rst;
   logic       ready;
   logic       fail;
   logic [1:0] retry_cnt;
   logic [7:0] lost_cnt;
   logic [2:0] state;

   pll_reset_sequencer #(
      .NUM_DOMAINS   (3),
      .RESET_CYCLES  (4),
      .LOCK_TIMEOUT  (32),
      .STABLE_CYCLES (8),
      .STAGGER_CYCLES(2),
      .MAX_RETRIES   (2),
      .CNT_W         (32)
   ) dut (
      .refclk    (refclk),
      .rst       (rst),
      .pll_locked(pll_locked),
      .relock_req(relock_req),
      .pll_rst   (pll_rst),
      .domain_rst(domain_rst),
      .ready     (ready),
      .fail      (fail),
      .retry_cnt (retry_cnt),
      .lost_cnt  (lost_cnt),
      .state     (state)
   );

   always #10 refclk = ~refclk;

   // {state, pll_rst, domain_rst, ready, fail, retry_cnt, lost_cnt}
   logic [18:0] obs;
   assign obs = {state, pll_rst, domain_rst, ready, fail, retry_cnt, lost_cnt};

   typedef struct {
      logic        rst;
      logic        lock;
      logic        req;
      logic [18:0] exp;
   } vec_t;

   vec_t vecs[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic push(input int n, input logic r, input logic l, input logic q,
                       input logic [2:0] st, input logic pr, input logic [2:0] dom,
                       input logic rdy, input logic fl, input logic [1:0] rc,
                       input logic [7:0] lc);
      vec_t v;
      v.rst  = r;
      v.lock = l;
      v.req  = q;
      v.exp  = {st, pr, dom, rdy, fl, rc, lc};
      for (int i = 0; i < n; i++) vecs.push_back(v);
   endtask

   task automatic tick();
      @(posedge refclk);
      #1;
   endtask

   task automatic check(input string name, input int idx, input logic [18:0] got,
                        input logic [18:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s[%0d] got=%h expected=%h", name, idx, got, exp);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int k;
      int exp_lost;
      rst        = 1'b1;
      pll_locked = 1'b0;
      relock_req = 1'b0;

      // Nominal bring-up: lock rises 10 cycles after pll_rst falls.
      push(3,  1,0,0, 3'd0,1,3'b111,0,0,2'd0,8'd0);
      push(3,  0,0,0, 3'd0,1,3'b111,0,0,2'd0,8'd0);
      push(10, 0,0,0, 3'd1,0,3'b111,0,0,2'd0,8'd0);
      push(2,  0,1,0, 3'd1,0,3'b111,0,0,2'd0,8'd0);
      push(8,  0,1,0, 3'd2,0,3'b111,0,0,2'd0,8'd0);
      push(2,  0,1,0, 3'd3,0,3'b110,0,0,2'd0,8'd0);
      push(2,  0,1,0, 3'd3,0,3'b100,0,0,2'd0,8'd0);
      push(3,  0,1,0, 3'd4,0,3'b000,1,0,2'd0,8'd0);
      // Lock loss in RUN, then full re-sequence.
      push(2,  0,0,0, 3'd4,0,3'b000,1,0,2'd0,8'd0);
      push(1,  0,0,0, 3'd0,1,3'b111,0,0,2'd0,8'd1);
      push(3,  0,1,0, 3'd0,1,3'b111,0,0,2'd0,8'd1);
      push(1,  0,1,0, 3'd1,0,3'b111,0,0,2'd0,8'd1);
      push(8,  0,1,0, 3'd2,0,3'b111,0,0,2'd0,8'd1);
      push(2,  0,1,0, 3'd3,0,3'b110,0,0,2'd0,8'd1);
      push(2,  0,1,0, 3'd3,0,3'b100,0,0,2'd0,8'd1);
      push(2,  0,1,0, 3'd4,0,3'b000,1,0,2'd0,8'd1);
      // relock_req in RUN, a second one ignored in RESET_PLL, then relock in RELEASE.
      push(1,  0,1,1, 3'd0,1,3'b111,0,0,2'd0,8'd1);
      push(1,  0,1,1, 3'd0,1,3'b111,0,0,2'd0,8'd1);
      push(2,  0,1,0, 3'd0,1,3'b111,0,0,2'd0,8'd1);
      push(1,  0,1,0, 3'd1,0,3'b111,0,0,2'd0,8'd1);
      push(8,  0,1,0, 3'd2,0,3'b111,0,0,2'd0,8'd1);
      push(1,  0,1,0, 3'd3,0,3'b110,0,0,2'd0,8'd1);
      push(1,  0,1,1, 3'd0,1,3'b111,0,0,2'd0,8'd1);
      push(3,  0,1,0, 3'd0,1,3'b111,0,0,2'd0,8'd1);
      push(1,  0,1,0, 3'd1,0,3'b111,0,0,2'd0,8'd1);
      push(8,  0,1,0, 3'd2,0,3'b111,0,0,2'd0,8'd1);
      push(1,  0,1,0, 3'd3,0,3'b110,0,0,2'd0,8'd1);
      // rst mid-release wipes everything, including lost_cnt.
      push(1,  1,1,0, 3'd0,1,3'b111,0,0,2'd0,8'd0);
      // Lock never asserts: two 32-cycle windows, then FAIL (lock ignored there).
      push(3,  0,0,0, 3'd0,1,3'b111,0,0,2'd0,8'd0);
      push(32, 0,0,0, 3'd1,0,3'b111,0,0,2'd0,8'd0);
      push(4,  0,0,0, 3'd0,1,3'b111,0,0,2'd1,8'd0);
      push(32, 0,0,0, 3'd1,0,3'b111,0,0,2'd1,8'd0);
      push(1,  0,0,0, 3'd5,0,3'b111,0,1,2'd2,8'd0);
      push(5,  0,1,0, 3'd5,0,3'b111,0,1,2'd2,8'd0);
      push(1,  0,0,1, 3'd0,1,3'b111,0,0,2'd0,8'd0);
      // Lock synchronized high exactly on the timeout cycle, then a 1-cycle glitch in STABLE.
      push(3,  0,0,0, 3'd0,1,3'b111,0,0,2'd0,8'd0);
      push(30, 0,0,0, 3'd1,0,3'b111,0,0,2'd0,8'd0);
      push(2,  0,1,0, 3'd1,0,3'b111,0,0,2'd0,8'd0);
      push(3,  0,1,0, 3'd2,0,3'b111,0,0,2'd0,8'd0);
      push(1,  0,0,0, 3'd2,0,3'b111,0,0,2'd0,8'd0);
      push(1,  0,1,0, 3'd2,0,3'b111,0,0,2'd0,8'd0);
      push(1,  0,1,0, 3'd1,0,3'b111,0,0,2'd0,8'd0);
      push(8,  0,1,0, 3'd2,0,3'b111,0,0,2'd0,8'd0);
      push(2,  0,1,0, 3'd3,0,3'b110,0,0,2'd0,8'd0);
      push(2,  0,1,0, 3'd3,0,3'b100,0,0,2'd0,8'd0);
      push(2,  0,1,0, 3'd4,0,3'b000,1,0,2'd0,8'd0);

      for (int i = 0; i < vecs.size(); i++) begin
         rst        = vecs[i].rst;
         pll_locked = vecs[i].lock;
         relock_req = vecs[i].req;
         tick();
         check("vec", i, obs, vecs[i].exp);
      end

      // 256 lock losses from RUN: lost_cnt must saturate at 255.
      rst        = 1'b0;
      relock_req = 1'b0;
      for (int i = 0; i < 256; i++) begin
         exp_lost   = (i + 1 > 255) ? 255 : i + 1;
         pll_locked = 1'b0;
         k = 0;
         while (state != 3'd0 && k < 6) begin
            tick();
            k++;
         end
         check("loss_cnt", i, {8'd0, state, lost_cnt}, {8'd0, 3'd0, 8'(exp_lost)});
         pll_locked = 1'b1;
         k = 0;
         while (!ready && k < 40) begin
            tick();
            k++;
         end
         check("relock_ready", i, {16'd0, state, ready} >> 1 << 1 | 19'(ready),
               {15'd0, 3'd4, 1'b1});
      end

      rst = 1'b1;
      tick();
      check("rst_final", 0, obs, {3'd0, 1'b1, 3'b111, 1'b0, 1'b0, 2'd0, 8'd0});
      rst = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
